mastermind_guess_scorer: RTL

//  Responder side of the core's check-guess request: accepts a one-cycle start with a packed

---
 rtl/mastermind_guess_scorer_pkg.sv | 19 +
 rtl/mastermind_guess_scorer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mastermind_guess_scorer_pkg.sv
// Shared definitions for the Mastermind guess scorer: FSM encoding, the empty colour
// code and default game geometry used by the core, top and renderer.
package mastermind_guess_scorer_pkg;

  localparam int DEF_NUM_PEGS   = 4;
  localparam int DEF_COLOR_W    = 3;
  localparam int DEF_NUM_COLORS = 7;

  // Colour code 0 means an unselected peg and never scores.
  localparam int COLOR_EMPTY = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXACT = 2'd1,
    ST_MATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mastermind_guess_scorer.sv
// Serial Mastermind scorer: one peg per cycle builds exact count and colour histograms,
// then one colour per cycle sums min(hist_g, hist_a) into the misplaced count.
module mastermind_guess_scorer
  import mastermind_guess_scorer_pkg::*;
#(
  parameter int NUM_PEGS   = DEF_NUM_PEGS,
  parameter int COLOR_W    = DEF_COLOR_W,
  parameter int NUM_COLORS = DEF_NUM_COLORS,
  parameter int CNT_W      = $clog2(NUM_PEGS + 1)
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        start,
  input  logic [NUM_PEGS*COLOR_W-1:0] guess,
  input  logic [NUM_PEGS*COLOR_W-1:0] answer,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            exact_cnt,
  output logic [CNT_W-1:0]            color_cnt,
  output logic                        all_correct,
  output logic                        invalid
);

  localparam int PEG_W = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;

  state_t                      state;
  logic [NUM_PEGS*COLOR_W-1:0] guess_q;
  logic [NUM_PEGS*COLOR_W-1:0] answer_q;
  logic [PEG_W-1:0]            peg_idx;
  logic [COLOR_W-1:0]          col_idx;
  logic [CNT_W-1:0]            exact_acc;
  logic [CNT_W-1:0]            color_acc;
  logic                        invalid_acc;
  logic [CNT_W-1:0]            hist_g [NUM_COLORS];
  logic [CNT_W-1:0]            hist_a [NUM_COLORS];

  logic [COLOR_W-1:0] g_peg;
  logic [COLOR_W-1:0] a_peg;
  logic [CNT_W-1:0]   hg_sel;
  logic [CNT_W-1:0]   ha_sel;
  logic [CNT_W-1:0]   color_sum;
  logic               guess_has_empty;

  // NOTE: every always_comb output gets a default before any conditional assignment,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    g_peg = '0;
    a_peg = '0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (peg_idx == PEG_W'(i)) begin
        g_peg = guess_q[i*COLOR_W +: COLOR_W];
        a_peg = answer_q[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_comb begin
    hg_sel = '0;
    ha_sel = '0;
    for (int c = 0; c < NUM_COLORS; c++) begin
      if (col_idx == COLOR_W'(c)) begin
        hg_sel = hist_g[c];
        ha_sel = hist_a[c];
      end
    end
    color_sum = color_acc + ((hg_sel < ha_sel) ? hg_sel : ha_sel);
  end

  always_comb begin
    guess_has_empty = 1'b0;
    for (int i = 0; i < NUM_PEGS; i++) begin
      if (guess[i*COLOR_W +: COLOR_W] == COLOR_W'(COLOR_EMPTY)) guess_has_empty = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      exact_cnt   <= '0;
      color_cnt   <= '0;
      all_correct <= 1'b0;
      invalid     <= 1'b0;
      guess_q     <= '0;
      answer_q    <= '0;
      peg_idx     <= '0;
      col_idx     <= '0;
      exact_acc   <= '0;
      color_acc   <= '0;
      invalid_acc <= 1'b0;
      // NOTE: the histograms are small flop arrays, not RAM, so resetting them is legal
      // and keeps a reset mid-operation from leaking counts into the next score.
      for (int c = 0; c < NUM_COLORS; c++) begin
        hist_g[c] <= '0;
        hist_a[c] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (start) begin
            state       <= ST_EXACT;
            busy        <= 1'b1;
            guess_q     <= guess;
            answer_q    <= answer;
            peg_idx     <= '0;
            col_idx     <= COLOR_W'(1);
            exact_acc   <= '0;
            color_acc   <= '0;
            invalid_acc <= guess_has_empty;
            for (int c = 0; c < NUM_COLORS; c++) begin
              hist_g[c] <= '0;
              hist_a[c] <= '0;
            end
          end
        end

        ST_EXACT: begin
          if (g_peg == a_peg && g_peg != COLOR_W'(COLOR_EMPTY)) begin
            exact_acc <= exact_acc + CNT_W'(1);
          end else begin
            // Codes beyond NUM_COLORS-1 have no histogram bin and are dropped.
            for (int c = 0; c < NUM_COLORS; c++) begin
              if (g_peg == COLOR_W'(c)) hist_g[c] <= hist_g[c] + CNT_W'(1);
              if (a_peg == COLOR_W'(c)) hist_a[c] <= hist_a[c] + CNT_W'(1);
            end
          end
          if (peg_idx == PEG_W'(NUM_PEGS - 1)) state   <= ST_MATCH;
          else                                 peg_idx <= peg_idx + PEG_W'(1);
        end

        ST_MATCH: begin
          color_acc <= color_sum;
          if (col_idx == COLOR_W'(NUM_COLORS - 1)) begin
            // Results load on the edge entering DONE so they are valid with the pulse.
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            exact_cnt   <= exact_acc;
            color_cnt   <= color_sum;
            all_correct <= (exact_acc == CNT_W'(NUM_PEGS));
            invalid     <= invalid_acc;
          end else begin
            col_idx <= col_idx + COLOR_W'(1);
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
